// File: rtl/rom_load_sched.sv
// ROM download sequencer for the Pleiads core: routes loader bytes into ROM/PROM regions,
// holds the core in reset while loading, and shares the storage port with CPU fetch.
module rom_load_sched #(
  parameter int PROG_BYTES = 16384,
  parameter int BG_BYTES   = 4096,
  parameter int FG_BYTES   = 4096,
  parameter int PROM_BYTES = 512,
  parameter int RESET_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        cpu_rd,
  input  logic [13:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_valid,
  output logic        cpu_wait,
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_din,
  output logic        rom_we,
  output logic [1:0]  rom_sel,
  input  logic [7:0]  rom_dout,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] load_sum
);

  localparam int                HOLD_W     = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [16:0]       BG_BASE    = 17'h04000;
  localparam logic [16:0]       FG_BASE    = 17'h05000;
  localparam logic [16:0]       PROM_BASE  = 17'h06000;
  localparam logic [16:0]       PROM_END   = PROM_BASE + 17'(PROM_BYTES);
  localparam logic [23:0]       LOAD_TOTAL = 24'(PROG_BYTES + BG_BYTES + FG_BYTES + PROM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t            state_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [23:0]       byte_cnt_r;
  logic              pend_r;
  logic [13:0]       pend_addr_r;
  logic              inflight_r;
  logic [7:0]        cpu_data_hold_r;

  logic [16:0] addr_ext_s;
  logic [13:0] base_s;
  logic [13:0] off_s;
  logic [1:0]  sel_s;
  logic        in_range_s;
  logic        enter_load_s;
  logic        hold_exit_s;
  logic        run_s;
  logic        accept_s;
  logic        want_s;
  logic        issue_s;
  logic [13:0] fetch_addr_s;

  // Region decode; bases are taken mod 2^14 since only the local offset matters.
  always_comb begin
    addr_ext_s = {1'b0, dn_addr};
    sel_s      = 2'd0;
    base_s     = 14'd0;
    in_range_s = 1'b1;
    if (addr_ext_s < BG_BASE) begin
      sel_s  = 2'd0;
      base_s = 14'd0;
    end else if (addr_ext_s < FG_BASE) begin
      sel_s  = 2'd1;
      base_s = BG_BASE[13:0];
    end else if (addr_ext_s < PROM_BASE) begin
      sel_s  = 2'd2;
      base_s = FG_BASE[13:0];
    end else if (addr_ext_s < PROM_END) begin
      sel_s  = 2'd3;
      base_s = PROM_BASE[13:0];
    end else begin
      sel_s      = 2'd0;
      base_s     = 14'd0;
      in_range_s = 1'b0;
    end
    off_s = dn_addr[13:0] - base_s;
  end

  // Fetch arbitration: a download write always owns the port for the next cycle.
  always_comb begin
    enter_load_s = dn_download && ((state_r == ST_IDLE) || (state_r == ST_RUN));
    hold_exit_s  = (state_r == ST_HOLD) && (hold_cnt_r == HOLD_LAST);
    run_s        = (state_r == ST_RUN) && !enter_load_s;
    accept_s     = run_s && cpu_rd && !pend_r && !inflight_r;
    want_s       = run_s && (pend_r || accept_s);
    issue_s      = want_s && !dn_wr;
    fetch_addr_s = pend_r ? pend_addr_r : cpu_addr;
  end

  // Sequencer state, core reset and load statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      core_reset <= 1'b1;
      byte_cnt_r <= 24'd0;
      load_sum   <= 16'd0;
      load_err   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dn_download) begin
            state_r <= ST_LOAD;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= ST_RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_LOAD: begin
          if (!dn_download) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_exit_s) begin
            state_r    <= ST_RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (dn_download) begin
            state_r    <= ST_LOAD;
            core_reset <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          core_reset <= 1'b1;
        end
      endcase

      // A byte written on the very edge that opens a load belongs to the new load.
      if (enter_load_s) begin
        byte_cnt_r <= dn_wr ? 24'd1 : 24'd0;
        load_sum   <= dn_wr ? {8'd0, dn_data} : 16'd0;
        load_err   <= dn_wr && !in_range_s;
        load_done  <= 1'b0;
      end else begin
        if (dn_wr) begin
          byte_cnt_r <= byte_cnt_r + 24'd1;
          load_sum   <= load_sum + {8'd0, dn_data};
        end
        load_err  <= load_err | (dn_wr && !in_range_s) | (hold_exit_s && (byte_cnt_r < LOAD_TOTAL));
        load_done <= load_done | hold_exit_s;
      end
    end
  end

  // Storage port driver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_we   <= 1'b0;
      rom_addr <= 14'd0;
      rom_din  <= 8'd0;
      rom_sel  <= 2'd0;
    end else if (dn_wr) begin
      rom_we   <= in_range_s;
      rom_addr <= off_s;
      rom_din  <= dn_data;
      rom_sel  <= sel_s;
    end else if (issue_s) begin
      rom_we   <= 1'b0;
      rom_addr <= fetch_addr_s;
      rom_sel  <= 2'd0;
    end else begin
      rom_we <= 1'b0;
    end
  end

  // Single-entry fetch tracking and return path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r          <= 1'b0;
      pend_addr_r     <= 14'd0;
      inflight_r      <= 1'b0;
      cpu_valid       <= 1'b0;
      cpu_wait        <= 1'b0;
      cpu_data_hold_r <= 8'd0;
    end else begin
      inflight_r <= issue_s;
      cpu_valid  <= inflight_r && run_s;
      cpu_wait   <= want_s && dn_wr;
      if (!run_s || issue_s) begin
        pend_r <= 1'b0;
      end else if (accept_s) begin
        pend_r      <= 1'b1;
        pend_addr_r <= cpu_addr;
      end else begin
        pend_r <= pend_r;
      end
      if (cpu_valid) begin
        cpu_data_hold_r <= rom_dout;
      end
    end
  end

  // Storage read data arrives in the valid cycle itself; the hold register keeps it afterwards.
  assign cpu_data = cpu_valid ? rom_dout : cpu_data_hold_r;

endmodule

// File: tb/tb_rom_load_sched.sv
// Directed bench for rom_load_sched: decode table, full/short loads, fetch timing and reset.
module tb_rom_load_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        cpu_rd;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_valid;
  logic        cpu_wait;
  logic [13:0] rom_addr;
  logic [7:0]  rom_din;
  logic        rom_we;
  logic [1:0]  rom_sel;
  logic [7:0]  rom_dout;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [15:0] load_sum;

  logic [7:0]  mem [0:16383];
  logic [23:0] exp_q [$];
  int errs = 0;
  int checks = 0;
  int we_cnt = 0;
  int k_run;
  int wcnt;
  int vat;
  int vflag;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [1:0]  sel;
    logic [13:0] off;
    logic        err;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  rom_load_sched #(
    .PROG_BYTES(16384), .BG_BYTES(4096), .FG_BYTES(4096), .PROM_BYTES(512), .RESET_HOLD(16)
  ) dut (
    .clk(clk), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_valid(cpu_valid), .cpu_wait(cpu_wait),
    .rom_addr(rom_addr), .rom_din(rom_din), .rom_we(rom_we), .rom_sel(rom_sel),
    .rom_dout(rom_dout), .core_reset(core_reset), .load_done(load_done),
    .load_err(load_err), .load_sum(load_sum)
  );

  // Program ROM model with one cycle of registered read latency.
  always @(posedge clk) begin
    if (rom_we && (rom_sel == 2'd0)) mem[rom_addr] <= rom_din;
    rom_dout <= mem[rom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_wr(input logic [15:0] a, input logic [7:0] d);
    if (a < 16'h4000)      return {2'd0, a[13:0], d};
    else if (a < 16'h5000) return {2'd1, 14'(a - 16'h4000), d};
    else if (a < 16'h6000) return {2'd2, 14'(a - 16'h5000), d};
    else                   return {2'd3, 14'(a - 16'h6000), d};
  endfunction

  // Advance one clock and check any storage write against the expected-write queue.
  task automatic tick();
    logic [23:0] e;
    @(posedge clk);
    #1;
    if (rom_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL wr_unexpected: got sel=%0d addr=0x%0h want no write", rom_sel, rom_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_port", {8'd0, rom_sel, rom_addr, rom_din}, {8'd0, e});
      end
    end
  endtask

  task automatic drive_wr(input logic [15:0] a, input logic [7:0] d);
    dn_wr   = 1'b1;
    dn_addr = a;
    dn_data = d;
    if (a < 16'h6200) exp_q.push_back(exp_wr(a, d));
  endtask

  task automatic wait_run(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!core_reset) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_load(input int n);
    dn_download = 1'b1;
    tick();
    for (int a = 0; a < n; a++) begin
      drive_wr(16'(a), 8'(a));
      tick();
    end
    dn_wr = 1'b0;
    dn_download = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_core_reset"}, 32'(core_reset), 32'd1);
    check({p, "_rom_we"},     32'(rom_we),     32'd0);
    check({p, "_rom_addr"},   32'(rom_addr),   32'd0);
    check({p, "_rom_din"},    32'(rom_din),    32'd0);
    check({p, "_rom_sel"},    32'(rom_sel),    32'd0);
    check({p, "_cpu_data"},   32'(cpu_data),   32'd0);
    check({p, "_cpu_valid"},  32'(cpu_valid),  32'd0);
    check({p, "_cpu_wait"},   32'(cpu_wait),   32'd0);
    check({p, "_load_done"},  32'(load_done),  32'd0);
    check({p, "_load_err"},   32'(load_err),   32'd0);
    check({p, "_load_sum"},   32'(load_sum),   32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 8'h11, 1'b1, 2'd0, 14'h0000, 1'b0};
    vecs[1] = '{16'h3FFF, 8'h22, 1'b1, 2'd0, 14'h3FFF, 1'b0};
    vecs[2] = '{16'h4000, 8'h33, 1'b1, 2'd1, 14'h0000, 1'b0};
    vecs[3] = '{16'h4FFF, 8'h44, 1'b1, 2'd1, 14'h0FFF, 1'b0};
    vecs[4] = '{16'h5003, 8'h55, 1'b1, 2'd2, 14'h0003, 1'b0};
    vecs[5] = '{16'h5FFF, 8'h66, 1'b1, 2'd2, 14'h0FFF, 1'b0};
    vecs[6] = '{16'h6000, 8'h77, 1'b1, 2'd3, 14'h0000, 1'b0};
    vecs[7] = '{16'h61FF, 8'h88, 1'b1, 2'd3, 14'h01FF, 1'b0};
    vecs[8] = '{16'h6200, 8'h99, 1'b0, 2'd0, 14'h0000, 1'b1};
    vecs[9] = '{16'h7000, 8'hAA, 1'b0, 2'd0, 14'h0000, 1'b1};

    reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = 16'd0; dn_data = 8'd0;
    cpu_rd = 1'b0; cpu_addr = 14'd0;
    #12;
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    wait_run(k_run);
    check("idle_to_run_cycles", 32'(k_run), 32'd16);
    check("idle_load_done", 32'(load_done), 32'd0);

    // Decode table inside one load.
    dn_download = 1'b1;
    tick();
    check("load_core_reset", 32'(core_reset), 32'd1);
    check("load_sum_clear", 32'(load_sum), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive_wr(vecs[i].addr, vecs[i].data);
      tick();
      dn_wr = 1'b0;
      check("tbl_we", 32'(rom_we), 32'(vecs[i].we));
      if (vecs[i].we) check("tbl_sel_off", {16'd0, rom_sel, rom_addr}, {16'd0, vecs[i].sel, vecs[i].off});
      check("tbl_err", 32'(load_err), 32'(vecs[i].err));
    end
    dn_download = 1'b0;
    tick();
    wait_run(k_run);
    check("tbl_hold_cycles", 32'(k_run), 32'd16);
    check("tbl_done", 32'(load_done), 32'd1);
    check("tbl_err_final", 32'(load_err), 32'd1);
    check("tbl_sum", 32'(load_sum), 32'h03A7);

    // Short load: program ROM only.
    we_cnt = 0;
    do_load(16384);
    wait_run(k_run);
    check("short_we_count", 32'(we_cnt), 32'd16384);
    check("short_hold_cycles", 32'(k_run), 32'd16);
    check("short_done", 32'(load_done), 32'd1);
    check("short_err", 32'(load_err), 32'd1);
    check("short_sum", 32'(load_sum), 32'hE000);

    // Full load.
    we_cnt = 0;
    do_load(25088);
    check("full_we_count", 32'(we_cnt), 32'd25088);
    check("full_sum", 32'(load_sum), 32'hCF00);
    wait_run(k_run);
    check("full_hold_cycles", 32'(k_run), 32'd16);
    check("full_done", 32'(load_done), 32'd1);
    check("full_err", 32'(load_err), 32'd0);

    // Uncontended fetch.
    cpu_rd = 1'b1; cpu_addr = 14'h0123;
    tick();
    cpu_rd = 1'b0;
    check("rd_issue_addr", 32'(rom_addr), 32'h0123);
    check("rd_issue_we", 32'(rom_we), 32'd0);
    check("rd_wait_n1", 32'(cpu_wait), 32'd0);
    check("rd_valid_n1", 32'(cpu_valid), 32'd0);
    tick();
    check("rd_valid_n2", 32'(cpu_valid), 32'd1);
    check("rd_data_n2", 32'(cpu_data), 32'h23);
    check("rd_wait_n2", 32'(cpu_wait), 32'd0);
    tick();
    check("rd_valid_n3", 32'(cpu_valid), 32'd0);
    check("rd_data_hold", 32'(cpu_data), 32'h23);

    // Fetch colliding with three forced writes.
    wcnt = 0; vat = 0;
    cpu_rd = 1'b1; cpu_addr = 14'h02A5;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 3) drive_wr(16'(15 + k), 8'(89 + k));
      else dn_wr = 1'b0;
      tick();
      cpu_rd = 1'b0;
      if (cpu_wait) wcnt++;
      if (cpu_valid) begin
        vat = k;
        check("col_data", 32'(cpu_data), 32'hA5);
      end
      if (k == 4) check("col_issue_addr", {17'd0, rom_we, rom_addr}, 32'h02A5);
    end
    check("col_wait_cycles", 32'(wcnt), 32'd3);
    check("col_valid_cycle", 32'(vat), 32'd5);
    check("col_writes_land", {8'd0, mem[16], mem[17], mem[18]}, 32'h005A5B5C);

    // Download rising while a fetch is in flight.
    cpu_rd = 1'b1; cpu_addr = 14'h0123;
    tick();
    cpu_rd = 1'b0;
    dn_download = 1'b1;
    tick();
    check("abort_core_reset", 32'(core_reset), 32'd1);
    check("abort_sum_clear", 32'(load_sum), 32'd0);
    vflag = cpu_valid ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_valid) vflag = 1;
    end
    check("abort_no_valid", 32'(vflag), 32'd0);
    drive_wr(16'h6001, 8'h42);
    tick();
    dn_wr = 1'b0;
    check("abort_new_sum", 32'(load_sum), 32'h0042);

    // Asynchronous reset in the middle of a load.
    drive_wr(16'h0005, 8'h07);
    tick();
    dn_wr = 1'b0;
    dn_download = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("arst");
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
